// File: rtl/axil_timer.sv
// axil_timer: memory-mapped 64-bit machine timer (mtime/mtimecmp) behind an
// AXI-Lite slave. It has a programmable prescaler and a level interrupt.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   s_axil_aw*/w*/b*    AXI-Lite write address, data and response channels
//   s_axil_ar*/r*       AXI-Lite read address and data channels
//   irq                 registered level interrupt: IE && (mtime >= mtimecmp)
//
// Register map (word offsets, addr[1:0] ignored):
//   0x00 MTIME_LO     0x04 MTIME_HI (returns the shadow taken by a MTIME_LO read)
//   0x08 MTIMECMP_LO  0x0C MTIMECMP_HI
//   0x10 CTRL {IE,EN} 0x14 PRESCALE   0x18 STATUS {PENDING}
//   All other offsets read 0 and ignore writes. Every response is OKAY.

module axil_timer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,

  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,

  output logic                  irq
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam int unsigned TIME_W = 2 * DATA_WIDTH;

  localparam logic [WORD_W-1:0] REG_MTIME_LO    = WORD_W'(0);
  localparam logic [WORD_W-1:0] REG_MTIME_HI    = WORD_W'(1);
  localparam logic [WORD_W-1:0] REG_MTIMECMP_LO = WORD_W'(2);
  localparam logic [WORD_W-1:0] REG_MTIMECMP_HI = WORD_W'(3);
  localparam logic [WORD_W-1:0] REG_CTRL        = WORD_W'(4);
  localparam logic [WORD_W-1:0] REG_PRESCALE    = WORD_W'(5);
  localparam logic [WORD_W-1:0] REG_STATUS      = WORD_W'(6);

  // Architectural state
  logic [TIME_W-1:0]     mtime;
  logic [TIME_W-1:0]     mtimecmp;
  logic                  ctrl_en;
  logic                  ctrl_ie;
  logic [DATA_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0] pcnt;
  logic [DATA_WIDTH-1:0] mtime_hi_shadow;

  // Bus handshake state
  logic                  aw_w_ready;
  logic                  bvalid;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  irq_q;

  logic                  wr_fire_c;
  logic                  rd_fire_c;
  logic [WORD_W-1:0]     wr_word_c;
  logic [WORD_W-1:0]     rd_word_c;
  logic                  tick_c;
  logic                  pending_c;
  logic [DATA_WIDTH-1:0] wr_old_c;
  logic [DATA_WIDTH-1:0] wr_new_c;
  logic [DATA_WIDTH-1:0] rd_val_c;

  // prot and the byte-offset address bits carry no meaning here
  logic unused_c;
  assign unused_c = ^{s_axil_awprot, s_axil_arprot,
                      s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign s_axil_awready = aw_w_ready;
  assign s_axil_wready  = aw_w_ready;
  assign s_axil_bvalid  = bvalid;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = arready;
  assign s_axil_rvalid  = rvalid;
  assign s_axil_rdata   = rdata;
  assign s_axil_rresp   = 2'b00;
  assign irq            = irq_q;

  // Merge write data into an old register value, byte by byte
  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] data,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
    end
    return res;
  endfunction

  assign wr_fire_c = aw_w_ready && s_axil_awvalid && s_axil_wvalid;
  assign rd_fire_c = arready && s_axil_arvalid;
  assign wr_word_c = s_axil_awaddr[ADDR_WIDTH-1:2];
  assign rd_word_c = s_axil_araddr[ADDR_WIDTH-1:2];
  assign tick_c    = ctrl_en && (pcnt == prescale);
  assign pending_c = (mtime >= mtimecmp);

  // Current value of the write target, used as the base for strobe merging
  always_comb begin
    wr_old_c = '0;
    case (wr_word_c)
      REG_MTIME_LO:    wr_old_c = mtime[DATA_WIDTH-1:0];
      REG_MTIME_HI:    wr_old_c = mtime[TIME_W-1:DATA_WIDTH];
      REG_MTIMECMP_LO: wr_old_c = mtimecmp[DATA_WIDTH-1:0];
      REG_MTIMECMP_HI: wr_old_c = mtimecmp[TIME_W-1:DATA_WIDTH];
      REG_CTRL:        wr_old_c = DATA_WIDTH'({ctrl_ie, ctrl_en});
      REG_PRESCALE:    wr_old_c = prescale;
      default:         wr_old_c = '0;
    endcase
  end

  assign wr_new_c = apply_strb(wr_old_c, s_axil_wdata, s_axil_wstrb);

  // Read mux; MTIME_HI returns the shadow so a LO/HI pair is coherent
  always_comb begin
    rd_val_c = '0;
    case (rd_word_c)
      REG_MTIME_LO:    rd_val_c = mtime[DATA_WIDTH-1:0];
      REG_MTIME_HI:    rd_val_c = mtime_hi_shadow;
      REG_MTIMECMP_LO: rd_val_c = mtimecmp[DATA_WIDTH-1:0];
      REG_MTIMECMP_HI: rd_val_c = mtimecmp[TIME_W-1:DATA_WIDTH];
      REG_CTRL:        rd_val_c = DATA_WIDTH'({ctrl_ie, ctrl_en});
      REG_PRESCALE:    rd_val_c = prescale;
      REG_STATUS:      rd_val_c = DATA_WIDTH'(pending_c);
      default:         rd_val_c = '0;
    endcase
  end

  // Write channel: AW and W are accepted together, one outstanding response
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_w_ready <= 1'b0;
      bvalid     <= 1'b0;
    end else begin
      aw_w_ready <= s_axil_awvalid && s_axil_wvalid && !aw_w_ready && !bvalid;
      if (wr_fire_c) begin
        bvalid <= 1'b1;
      end else if (s_axil_bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read channel: rdata is captured at accept and held until rready
  always_ff @(posedge clk) begin
    if (rst) begin
      arready         <= 1'b0;
      rvalid          <= 1'b0;
      rdata           <= '0;
      mtime_hi_shadow <= '0;
    end else begin
      arready <= s_axil_arvalid && !arready && !rvalid;
      if (rd_fire_c) begin
        rvalid <= 1'b1;
        rdata  <= rd_val_c;
        if (rd_word_c == REG_MTIME_LO) begin
          mtime_hi_shadow <= mtime[TIME_W-1:DATA_WIDTH];
        end
      end else if (s_axil_rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Prescaler and mtime; a bus write to either mtime half overrides the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      mtime <= '0;
    end else begin
      if (ctrl_en) begin
        pcnt <= tick_c ? '0 : pcnt + DATA_WIDTH'(1);
      end
      if (wr_fire_c && (wr_word_c == REG_PRESCALE)) begin
        pcnt <= '0;
      end

      if (tick_c) begin
        mtime <= mtime + TIME_W'(1);
      end
      if (wr_fire_c && (wr_word_c == REG_MTIME_LO)) begin
        mtime <= {mtime[TIME_W-1:DATA_WIDTH], wr_new_c};
      end else if (wr_fire_c && (wr_word_c == REG_MTIME_HI)) begin
        mtime <= {wr_new_c, mtime[DATA_WIDTH-1:0]};
      end
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      ctrl_en  <= 1'b0;
      ctrl_ie  <= 1'b0;
      prescale <= '0;
    end else if (wr_fire_c) begin
      case (wr_word_c)
        REG_MTIMECMP_LO: mtimecmp[DATA_WIDTH-1:0]      <= wr_new_c;
        REG_MTIMECMP_HI: mtimecmp[TIME_W-1:DATA_WIDTH] <= wr_new_c;
        REG_CTRL: begin
          ctrl_en <= wr_new_c[0];
          ctrl_ie <= wr_new_c[1];
        end
        REG_PRESCALE:    prescale <= wr_new_c;
        default:         ;
      endcase
    end
  end

  // Interrupt follows the compare one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ctrl_ie && pending_c;
    end
  end

endmodule
